// File: rtl/io_pkg.sv
// io_pkg: shared register offsets, bit positions and reset values for the IO window blocks
package io_pkg;
  typedef enum logic [1:0] {
    SEG_SHADOW = 2'd0,
    SEG_CTRL   = 2'd1,
    SEG_STATUS = 2'd2,
    SEG_ACTIVE = 2'd3
  } seg_reg_e;
  localparam int CTRL_EN = 0;
  localparam int CTRL_LZB = 1;
  localparam int CTRL_DP_LSB = 8;
  localparam int STAT_FRAME_DONE = 0;
  localparam int STAT_PENDING = 1;
  localparam logic [31:0] CTRL_RESET = 32'h0000_0001;
  // Only EN, LZB and the DP mask are implemented; everything else reads back 0.
  localparam logic [31:0] CTRL_MASK = 32'h0000_FF03;
endpackage

// File: rtl/seg7_display_ctrl_if.sv
// seg7_display_ctrl_if: IO-window bus between the data-memory decoder and the display controller
//   we     write strobe, one cycle per store
//   addr   word offset within the block's window
//   wdata  store data
//   rdata  load data, combinational from addr
interface seg7_display_ctrl_if;
  logic we;
  logic [1:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master(output we, addr, wdata, input rdata);
  modport slave(input we, addr, wdata, output rdata);
endinterface

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}
//   nib  in   4-bit value
//   seg  out  7-bit segments, 0 lights a segment
module hex_to_seg7 (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  assign seg = FONT[nib];
endmodule

// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl: memory-mapped, double-buffered 8-digit common-anode seven-segment scanner
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    IO-window slave port (we/addr/wdata in, rdata out)
//   AN     digit anodes, active low
//   DP     decimal point, active low
//   A2G    segments {g,f,e,d,c,b,a}, active low
module seg7_display_ctrl
  import io_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DIGITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  seg7_display_ctrl_if.slave  bus,
  output logic [7:0]          AN,
  output logic                DP,
  output logic [6:0]          A2G
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [31:0] shadow, active, ctrl;
  logic frame_done, pending;
  logic en, tc, wrap, wr_sh, wr_ctrl, wr_stat, blank;
  logic [3:0] nib;
  logic [6:0] seg;
  assign en = ctrl[CTRL_EN];
  assign tc = en && cnt == CW'(SCAN_DIV - 1);
  assign wrap = tc && idx == 3'(DIGITS - 1);
  assign wr_sh = bus.we && bus.addr == SEG_SHADOW;
  assign wr_ctrl = bus.we && bus.addr == SEG_CTRL;
  assign wr_stat = bus.we && bus.addr == SEG_STATUS;
  assign nib = active[{idx, 2'b00} +: 4];
  // Leading-zero blanking: a digit goes dark when it and every digit above it are zero.
  assign blank = !en || (ctrl[CTRL_LZB] && idx != 3'd0 && (active >> {idx, 2'b00}) == 32'd0);
  assign bus.rdata = bus.addr == SEG_SHADOW ? shadow :
                     bus.addr == SEG_CTRL   ? ctrl :
                     bus.addr == SEG_STATUS ? {30'b0, pending, frame_done} : active;
  hex_to_seg7 u_font (.nib(nib), .seg(seg));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
      shadow <= '0;
      active <= '0;
      ctrl <= CTRL_RESET;
      frame_done <= 1'b0;
      pending <= 1'b0;
      AN <= 8'hFF;
      A2G <= 7'h7F;
      DP <= 1'b1;
    end else begin
      cnt <= (!en || tc) ? '0 : cnt + 1'b1;
      idx <= !en ? '0 : tc ? idx + 1'b1 : idx;
      // The copy uses the pre-write shadow, so a store on the wrap cycle waits for the next frame.
      if (!en || wrap) active <= shadow;
      if (wr_sh) shadow <= bus.wdata;
      if (wr_ctrl) ctrl <= bus.wdata & CTRL_MASK;
      pending <= wr_sh || (pending && en && !wrap);
      frame_done <= wrap || (frame_done && !(wr_stat && bus.wdata[STAT_FRAME_DONE]));
      AN <= blank ? 8'hFF : ~(8'd1 << idx);
      A2G <= blank ? 7'h7F : seg;
      DP <= blank ? 1'b1 : ~ctrl[CTRL_DP_LSB + idx];
    end
  end
endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb_seg7_display_ctrl: directed scoreboard bench for seg7_display_ctrl with SCAN_DIV=4
module tb_seg7_display_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] AN;
  logic DP;
  logic [6:0] A2G;
  int edges, checks, errors;
  logic [31:0] exp_q[$];
  string tag_q[$];
  seg7_display_ctrl_if bus();
  seg7_display_ctrl #(.SCAN_DIV(4), .DIGITS(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .AN(AN), .DP(DP), .A2G(A2G)
  );
  always #5 clk = ~clk;
  // Rising edges since reset release; edge k sees idx ((k-1)/4)%8 and count (k-1)%4 while enabled.
  always @(posedge clk or posedge reset) edges <= reset ? 0 : edges + 1;
  task automatic push(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask
  task automatic exp_pins(input string t, input logic [7:0] an, input logic [6:0] a2g, input logic dp);
    push({t, "_an"}, {24'b0, an});
    push({t, "_a2g"}, {25'b0, a2g});
    push({t, "_dp"}, {31'b0, dp});
  endtask
  task automatic pop(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed %h", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", t, obs, e);
    end
  endtask
  task automatic pins;
    pop({24'b0, AN});
    pop({25'b0, A2G});
    pop({31'b0, DP});
  endtask
  task automatic go(input int e);
    int g = 0;
    while (edges < e && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (edges != e) begin
      checks++;
      errors++;
      $error("FAIL sync_%0d observed %0d expected %0d", e, edges, e);
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.we = 1'b1;
    bus.addr = a;
    bus.wdata = d;
    @(negedge clk);
    bus.we = 1'b0;
  endtask
  task automatic rd(input logic [1:0] a);
    bus.addr = a;
    #1;
    pop(bus.rdata);
  endtask
  initial begin
    bus.we = 1'b0;
    bus.addr = 2'd0;
    bus.wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_pins("scan_d1", 8'hFD, 7'h40, 1'b1);
    go(6); pins();
    exp_pins("rst", 8'hFF, 7'h7F, 1'b1);
    push("rst_ctrl", 32'h0000_0001);
    push("rst_status", 32'h0);
    reset = 1'b1;
    #1; pins(); rd(2'd1); rd(2'd2);
    @(negedge clk);
    reset = 1'b0;
    go(12); wr(2'd0, 32'h1234_5678);
    exp_pins("db_hold", 8'hEF, 7'h40, 1'b1);
    push("db_pending", 32'h2);
    exp_pins("db_last_old", 8'h7F, 7'h40, 1'b1);
    exp_pins("db_new", 8'hFE, 7'h00, 1'b1);
    push("db_status", 32'h1);
    push("db_active", 32'h1234_5678);
    go(20); pins(); rd(2'd2);
    go(32); pins();
    go(33); pins(); rd(2'd2); rd(2'd3);
    go(39); wr(2'd0, 32'h0000_00A5);
    go(63); wr(2'd0, 32'hFFFF_FFFF);
    push("col_active", 32'h0000_00A5);
    push("col_status", 32'h3);
    exp_pins("col_a5", 8'hFE, 7'h12, 1'b1);
    exp_pins("col_ff", 8'hFE, 7'h0E, 1'b1);
    push("col_status2", 32'h1);
    rd(2'd3); rd(2'd2);
    go(65); pins();
    go(97); pins(); rd(2'd2);
    wr(2'd1, 32'h0000_0003);
    wr(2'd0, 32'h0000_0012);
    wr(2'd3, 32'hDEAD_BEEF);
    push("ro_active", 32'hFFFF_FFFF);
    rd(2'd3);
    exp_pins("blk_d0", 8'hFE, 7'h24, 1'b1);
    exp_pins("blk_d1", 8'hFD, 7'h79, 1'b1);
    exp_pins("blk_d2", 8'hFF, 7'h7F, 1'b1);
    go(129); pins();
    go(133); pins();
    go(137); pins();
    go(139); wr(2'd0, 32'h0);
    exp_pins("blk_d7", 8'hFF, 7'h7F, 1'b1);
    exp_pins("zero_d0", 8'hFE, 7'h40, 1'b1);
    exp_pins("zero_d1", 8'hFF, 7'h7F, 1'b1);
    go(157); pins();
    go(161); pins();
    go(165); pins();
    go(169); wr(2'd1, 32'h0000_8001);
    exp_pins("dp_d6", 8'hBF, 7'h40, 1'b1);
    exp_pins("dp_d7", 8'h7F, 7'h40, 1'b0);
    go(185); pins();
    go(189); pins();
    go(193); wr(2'd2, 32'h1);
    push("clr_status", 32'h0);
    rd(2'd2);
    go(223); wr(2'd2, 32'h1);
    push("clr_on_wrap", 32'h1);
    rd(2'd2);
    go(229); wr(2'd1, 32'h0);
    exp_pins("dis_dark", 8'hFF, 7'h7F, 1'b1);
    go(231); pins();
    wr(2'd0, 32'h0000_0009);
    push("dis_act_pre", 32'h0);
    push("dis_act", 32'h9);
    rd(2'd3);
    go(233); rd(2'd3);
    go(239); wr(2'd1, 32'h1);
    exp_pins("reen_dark", 8'hFF, 7'h7F, 1'b1);
    exp_pins("reen_d0", 8'hFE, 7'h10, 1'b1);
    exp_pins("reen_d1", 8'hFD, 7'h40, 1'b1);
    pins();
    go(241); pins();
    go(245); pins();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_display_ctrl.md
Name: seg7_display_ctrl

Overview:
- Memory-mapped seven-segment display controller; the display-output end of the CPU's IO write path.
- Sits behind the data-memory decoder: the decoder steers CPU stores and loads in the IO window to this block.
- The block scans 8 common-anode digits on the board pins AN/A2G/DP.
- DATA writes are double-buffered so the display never tears mid-frame.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz); minimum 2.
- DIGITS, 8: number of digits scanned; fixed at 8 in this revision.

Ports:
- clk  in  1  system clock (CPU clock domain)
- reset  in  1  asynchronous, active-high reset
- we  in  1  write strobe from decoder, one cycle per store
- addr  in  2  word offset within the block's IO window
- wdata  in  32  store data
- rdata  out  32  load data, combinational from addr
- AN  out  8  digit anodes, active low
- DP  out  1  decimal point, active low
- A2G  out  7  segments {g,f,e,d,c,b,a}, active low

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Register map (word offsets):
  - 0 SHADOW: R/W.
  - 1 CTRL: R/W. bit0 EN, bit1 LZB (leading-zero blank), bits[15:8] DP mask (bit i lights DP of digit i). Other bits read 0.
  - 2 STATUS: bit0 FRAME_DONE (sticky, write 1 to clear), bit1 PENDING (read only).
  - 3 ACTIVE: read only.
- Reset values:
  - shadow = active = 0; CTRL = 0x0000_0001; FRAME_DONE = PENDING = 0.
  - Scan counter = 0; digit idx = 0.
  - AN = 8'hFF, A2G = 7'h7F, DP = 1 (all dark).
- Scan:
  - Counter counts 0..SCAN_DIV-1.
  - At terminal count, idx <= idx+1 mod 8 (7 wraps to 0).
- Frame wrap tick (terminal count with idx==7):
  - active <= shadow.
  - PENDING <= 0.
  - FRAME_DONE <= 1.
- Write to offset 0: shadow <= wdata, PENDING <= 1.
  - Simultaneous write and wrap tick: active takes the pre-write shadow; PENDING stays 1.
- Write to offset 2 with wdata[0]=1 clears FRAME_DONE; a same-cycle wrap tick wins (FRAME_DONE = 1).
- Writes to offset 3 are ignored.
- Outputs are registered, one cycle after idx, counter or active change:
  - nib = active[4*idx+3 : 4*idx].
  - A2G = hex font of nib: 0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00, F -> 7'h0E.
  - DP = ~CTRL[8+idx].
  - AN = ~(1<<idx), unless blanked.
- Blanking:
  - When LZB=1, digit idx>0 is blanked if nibbles 7..idx are all zero. Digit 0 is never blanked.
  - A blanked digit gives AN = 8'hFF, A2G = 7'h7F, DP = 1.
- EN=0:
  - Counter and idx held at 0; outputs dark.
  - active <= shadow every cycle; PENDING <= 0; FRAME_DONE unchanged.
  - On EN 0->1, scanning restarts at digit 0, count 0.
- Reset mid-frame returns everything to reset values immediately (asynchronous); shadow contents are lost.
- rdata: offset 0 shadow, 1 CTRL, 2 {30'b0, PENDING, FRAME_DONE}, 3 active.

Decomposition:
- Shared package io_pkg holds:
  - Register offset constants (SEG_SHADOW=0, SEG_CTRL=1, SEG_STATUS=2, SEG_ACTIVE=3).
  - CTRL bit positions (CTRL_EN=0, CTRL_LZB=1, CTRL_DP_LSB=8).
  - STATUS bit positions.
  - Reset value of CTRL.
- One combinational sub-module, hex_to_seg7 (4-bit nibble in, 7-bit active-low segments out), reusable by other IO blocks.

Test Plan:
- All scenarios use SCAN_DIV=4.
- Reset: assert reset mid-scan -> AN=FF, A2G=7F, DP=1 immediately; rdata@1 = 0x0000_0001.
- Double buffer: write 0x1234_5678 to offset 0 at idx=3 -> digits keep showing 0 until the wrap tick. Then idx0 shows A2G=7'h00 ('8') with AN=FE; STATUS reads 0x1 (PENDING=0, FRAME_DONE=1).
- Collision: write 0xFFFF_FFFF on the exact wrap-tick cycle, after a prior 0x0000_00A5 -> active = 0x0000_00A5, PENDING=1. At the next wrap, active = 0xFFFF_FFFF and digit 0 shows A2G=7'h0E.
- Blanking: CTRL=0x0000_0003, active=0x0000_0012 -> AN stays FF in slots idx 2..7. Slots 0 and 1 show 7'h79 ('1', idx 1) and 7'h24 ('2', idx 0). active=0 -> only digit 0 lit, showing 7'h40.
- DP and clear: CTRL=0x0000_8001 -> DP=0 only while idx=7. Write 1 to offset 2 on a non-wrap cycle -> FRAME_DONE reads 0. Write on a wrap cycle -> FRAME_DONE reads 1.
- Disable: CTRL=0 -> AN=FF within 1 cycle; shadow write 0x0000_0009 reads back at offset 3 the next cycle. Re-enable -> first lit slot is idx 0 with A2G=7'h10 ('9').
